conv_sequencer: RTL and testbench
=================================

# conv_sequencer

Host-side controller for the convolution engine. It accepts a host stream of kernel words followed by matrix words over a valid/ready handshake, and drives the engine's load controls to write them. It then runs the convolution pass and collects one result per output position into a result FIFO, which the host drains over a second valid/ready handshake. It sits between the system bus adapter and the engine, and is the only block that toggles the engine's mode pins.

## Interface
- `MATRIX_DIM`, default 16: matrix side length; must match the engine.
- `CONV_DIM`, default 3: kernel side length; must match the engine.
- `RESULT_DEPTH`, default 4: result FIFO entries, power of two, ≥2.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a job; sampled only in IDLE.
- `in_valid` in 1: host data valid.
- `in_ready` out 1: sequencer accepts host data.
- `in_data` in `DATA_WIDTH`: kernel words (row-major), then matrix words (row-major).
- `out_valid` out 1: result available.
- `out_ready` in 1: host accepts result.
- `out_data` out `DATA_WIDTH`: result word.
- `out_last` out 1: marks the final result of a job.
- `busy` out 1: state ≠ IDLE.
- `overflow` out 1: sticky; a result was dropped because the FIFO was full.
- `tpu_rst` out 1: engine reset.
- `tpu_insert_kernal`, `tpu_write_mode`, `tpu_write`, `tpu_ready` out 1 each: engine controls.
- `tpu_data_in` out `DATA_WIDTH`: equals `in_data`, combinational.
- `tpu_done` in 1, `tpu_data_out` in `DATA_WIDTH`: engine result strobe and value.

## Operation
- Constants: `KWORDS = CONV_DIM*CONV_DIM`; `MWORDS = MATRIX_DIM*MATRIX_DIM`; `NRES = MWORDS`.
- Counter widths are `$clog2(MWORDS)+1`. Counters never wrap within a state.
- States: IDLE, CLEAR, LOAD_K, LOAD_M, COMPUTE, DRAIN.
- IDLE
  - All `tpu_*` controls are 0.
  - `start` → CLEAR.
  - Entering CLEAR clears `overflow` and all counters.
- CLEAR
  - `tpu_rst=1` for exactly one cycle, which realigns the engine's address counters. Then → LOAD_K.
- LOAD_K
  - `tpu_write_mode=1`, `tpu_insert_kernal=1`, `tpu_ready=1`, `in_ready=1`.
  - `tpu_write = in_valid & in_ready`.
  - When the KWORDS-th word is accepted → LOAD_M.
- LOAD_M
  - As LOAD_K, but `tpu_insert_kernal=0`.
  - When the MWORDS-th word is accepted → COMPUTE.
- COMPUTE
  - `tpu_write_mode=0`, `tpu_write=0`, `tpu_ready=1`, `in_ready=0`.
  - Each cycle with `tpu_done=1` pushes `tpu_data_out` to the FIFO with a last-tag equal to (result count == NRES-1).
  - The result counter increments on every `tpu_done`, whether or not the push succeeds.
  - When the NRES-th `tpu_done` arrives → DRAIN.
- DRAIN
  - Engine idle, as in IDLE.
  - When the FIFO is empty → IDLE.
- FIFO full on `tpu_done`
  - If `out_valid & out_ready` in the same cycle: push is accepted (simultaneous pop).
  - Otherwise: result dropped and `overflow` set.
- `out_last` is the last-tag of the head entry. It is never asserted if that result was dropped.
- `in_ready=0` in every state except LOAD_K/LOAD_M. Words offered outside those states are not consumed.

## Timing
- Reset values
  - State IDLE; FIFO empty.
  - `in_ready`, `out_valid`, `out_last`, `busy`, `overflow` = 0; `out_data` = 0.
  - All `tpu_*` controls = 0, except `tpu_rst`, which is 1 during `rst`.
- `rst` mid-job: returns to IDLE the next cycle. FIFO contents are discarded and `overflow` is cleared.
- `start` high at edge N: CLEAR during cycle N+1, `in_ready=1` from N+2.
- Throughput
  - One host word per cycle while loading.
  - No bubble between LOAD_K and LOAD_M.
  - The first matrix word can be accepted the cycle after the last kernel word.
- Result path
  - `tpu_done` at edge N gives `out_valid=1` at N+1 if the FIFO was empty (registered FIFO, no bypass).
  - `out_data` is stable while `out_valid & ~out_ready`.
- `start` while `busy` is ignored.
- `busy` deasserts the cycle after the last result pops.

## Configuration
- `CONV_SEQ_PERF_EN` defined:
  - Adds output `cycles` [31:0], counting cycles spent in COMPUTE for the current job.
  - Cleared in CLEAR, saturates at all-ones, held in IDLE.
- Not defined: no `cycles` port and no counter logic. All other behaviour is identical.

## Structure
- The package (`defines.vh` scope) holds:
  - the `conv_seq_state_t` enum;
  - the `KWORDS`/`MWORDS` helper functions;
  - the FIFO entry struct `{logic last; data_t data;}`.
- `data_t` and `DATA_WIDTH` come from the existing shared defines.
- One sub-module: `result_fifo`, a parameterised synchronous FIFO (`DEPTH`, entry type), with push/pop, full/empty and registered head.

## Test plan
1. **Identity kernel.** CONV_DIM=3 with centre weight 1; matrix word(i)=i, MATRIX_DIM=4; `out_ready`=1. Expect 16 results matching the golden model, `out_last` only on the 16th, `overflow`=0.
2. **Input backpressure.** `in_valid` toggles 1,0,1,0 → `tpu_write` pulses only on accepted beats; the state reaches COMPUTE after exactly 9+16 accepts.
3. **Output stall.** `out_ready`=0 throughout COMPUTE with RESULT_DEPTH=4 → 4 results held, `overflow`=1, remaining results dropped. Releasing `out_ready` yields 4 words, then IDLE.
4. **Push/pop when full.** FIFO full, `tpu_done` and pop in the same cycle → no overflow and ordering preserved.
5. **Reset mid-job.** `rst` asserted during LOAD_M → next cycle IDLE, `busy`=0. A fresh job then produces correct results.
6. **Start ignored while busy.** `start` pulsed while in COMPUTE → no CLEAR and no `tpu_rst`. With `CONV_SEQ_PERF_EN` defined, `cycles` equals the cycles spent in COMPUTE.

Source files
------------

// File: rtl/conv_sequencer_pkg.sv
// rtl/conv_sequencer_pkg.sv - shared types and sizing helpers for the convolution sequencer
package conv_sequencer_pkg;

  localparam int DATA_WIDTH = 16;
  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD_K,
    ST_LOAD_M,
    ST_COMPUTE,
    ST_DRAIN
  } conv_seq_state_t;

  typedef struct packed {
    logic  last;
    data_t data;
  } fifo_entry_t;

  function automatic int kwords(input int conv_dim);
    return conv_dim * conv_dim;
  endfunction

  function automatic int mwords(input int matrix_dim);
    return matrix_dim * matrix_dim;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous FIFO with registered storage; a pop frees a slot for a same-cycle push
module result_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [7:0]
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - loads kernel/matrix into the engine, collects results into a FIFO
// Defining CONV_SEQ_PERF_EN adds the 'cycles' output counting COMPUTE cycles per job.
module conv_sequencer
  import conv_sequencer_pkg::*;
#(
  parameter int MATRIX_DIM   = 16,
  parameter int CONV_DIM     = 3,
  parameter int RESULT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  data_t       in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output data_t       out_data,
  output logic        out_last,
  output logic        busy,
  output logic        overflow,
  output logic        tpu_rst,
  output logic        tpu_insert_kernal,
  output logic        tpu_write_mode,
  output logic        tpu_write,
  output logic        tpu_ready,
  output data_t       tpu_data_in,
  input  logic        tpu_done,
  input  data_t       tpu_data_out
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0] cycles
`endif
);

  localparam int KW   = kwords(CONV_DIM);
  localparam int MW   = mwords(MATRIX_DIM);
  localparam int NRES = MW;
  localparam int CW   = $clog2(MW) + 1;

  conv_seq_state_t state;
  logic [CW-1:0]   in_cnt;
  logic [CW-1:0]   res_cnt;
  logic            loading;
  logic            accept;
  logic            push;
  logic            pop_hs;
  logic            fifo_full;
  logic            fifo_empty;
  fifo_entry_t     push_entry;
  fifo_entry_t     head;

  // Engine controls are forced low while rst is held, whatever the state register says.
  assign loading           = (state == ST_LOAD_K || state == ST_LOAD_M) && !rst;
  assign in_ready          = loading;
  assign accept            = in_valid && loading;
  assign tpu_data_in       = in_data;
  assign tpu_rst           = rst || (state == ST_CLEAR);
  assign tpu_write_mode    = loading;
  assign tpu_write         = accept;
  assign tpu_insert_kernal = (state == ST_LOAD_K) && !rst;
  assign tpu_ready         = (loading || state == ST_COMPUTE) && !rst;
  assign busy              = (state != ST_IDLE);

  assign out_valid = !fifo_empty;
  assign out_data  = head.data;
  assign out_last  = head.last && !fifo_empty;
  assign pop_hs    = out_valid && out_ready;
  assign push      = (state == ST_COMPUTE) && tpu_done;

  assign push_entry.last = (res_cnt == CW'(NRES - 1));
  assign push_entry.data = tpu_data_out;

  result_fifo #(
    .DEPTH   (RESULT_DEPTH),
    .entry_t (fifo_entry_t)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop_hs),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      in_cnt   <= '0;
      res_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_CLEAR;
            in_cnt   <= '0;
            res_cnt  <= '0;
            overflow <= 1'b0;
          end
        end
        ST_CLEAR: state <= ST_LOAD_K;
        ST_LOAD_K: begin
          if (accept) begin
            if (in_cnt == CW'(KW - 1)) begin
              state  <= ST_LOAD_M;
              in_cnt <= '0;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        ST_LOAD_M: begin
          if (accept) begin
            if (in_cnt == CW'(MW - 1)) begin
              state  <= ST_COMPUTE;
              in_cnt <= '0;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          // A full FIFO only takes the result if the head leaves in the same cycle.
          if (tpu_done) begin
            if (fifo_full && !pop_hs) overflow <= 1'b1;
            if (res_cnt == CW'(NRES - 1)) state <= ST_DRAIN;
            res_cnt <= res_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CONV_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || state == ST_CLEAR) begin
      cycles <= '0;
    end else if (state == ST_COMPUTE && cycles != '1) begin
      cycles <= cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - directed self-checking bench for conv_sequencer with an engine stand-in
module tb_conv_sequencer;
  import conv_sequencer_pkg::*;

  localparam int MD = 4;
  localparam int CD = 3;
  localparam int RD = 4;
  localparam int NR = MD * MD;
  localparam int NW = CD * CD + MD * MD;

  logic  clk = 1'b0;
  logic  rst, start, in_valid, in_ready, out_valid, out_ready, out_last, busy, overflow;
  logic  tpu_rst, tpu_insert_kernal, tpu_write_mode, tpu_write, tpu_ready, tpu_done;
  data_t in_data, out_data, tpu_data_in, tpu_data_out;
`ifdef CONV_SEQ_PERF_EN
  logic [31:0] cycles;
`endif

  int tests = 0;
  int fails = 0;
  int kern [CD*CD];
  int mat  [NR];
  int res  [NR];

  always #5 clk = ~clk;

  conv_sequencer #(
    .MATRIX_DIM   (MD),
    .CONV_DIM     (CD),
    .RESULT_DEPTH (RD)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_last          (out_last),
    .busy              (busy),
    .overflow          (overflow),
    .tpu_rst           (tpu_rst),
    .tpu_insert_kernal (tpu_insert_kernal),
    .tpu_write_mode    (tpu_write_mode),
    .tpu_write         (tpu_write),
    .tpu_ready         (tpu_ready),
    .tpu_data_in       (tpu_data_in),
    .tpu_done          (tpu_done),
    .tpu_data_out      (tpu_data_out)
`ifdef CONV_SEQ_PERF_EN
    ,
    .cycles            (cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Zero-padded "same" convolution of mat with kern.
  task automatic compute_golden;
    for (int r = 0; r < MD; r++) begin
      for (int c = 0; c < MD; c++) begin
        int s;
        s = 0;
        for (int kr = 0; kr < CD; kr++) begin
          for (int kc = 0; kc < CD; kc++) begin
            int mr, mc;
            mr = r + kr - 1;
            mc = c + kc - 1;
            if (mr >= 0 && mr < MD && mc >= 0 && mc < MD)
              s += kern[kr*CD + kc] * mat[mr*MD + mc];
          end
        end
        res[r*MD + c] = s;
      end
    end
  endtask

  task automatic start_job;
    start = 1'b1;
    step;
    start = 1'b0;
    check("clear_tpu_rst", tpu_rst, 1);
    check("clear_busy", busy, 1);
    check("clear_overflow", overflow, 0);
    check("clear_in_ready", in_ready, 0);
    step;
    check("loadk_in_ready", in_ready, 1);
    check("loadk_tpu_rst", tpu_rst, 0);
  endtask

  task automatic load(input bit toggle, input int nwords);
    int idx, cyc;
    idx = 0;
    cyc = 0;
    while (idx < nwords && cyc < 200) begin
      in_valid = toggle ? ~cyc[0] : 1'b1;
      in_data  = (idx < CD*CD) ? data_t'(kern[idx]) : data_t'(mat[idx - CD*CD]);
      #1;
      check("load_ctl", {tpu_write, tpu_insert_kernal, tpu_write_mode, tpu_ready, tpu_data_in == in_data},
            {in_valid, idx < CD*CD, 1'b1, 1'b1, 1'b1});
      if (in_valid) idx++;
      cyc++;
      step;
    end
    in_valid = 1'b0;
    check("load_accepts", idx, nwords);
  endtask

  task automatic check_in_compute;
    check("compute_in_ready", in_ready, 0);
    check("compute_ctl", {tpu_write_mode, tpu_write, tpu_ready, tpu_insert_kernal}, 4'b0010);
  endtask

  // mode 0: host always ready; 1: host stalled until after the job; 2: stalled for the first RD results.
  task automatic compute(input int mode, input bit poke);
    int sent, got, cyc, expn;
    sent = 0;
    got  = 0;
    cyc  = 0;
    expn = (mode == 1) ? RD : NR;
    while ((sent < NR || busy) && cyc < 200) begin
      tpu_done     = (sent < NR);
      tpu_data_out = (sent < NR) ? data_t'(res[sent]) : '0;
      case (mode)
        1:       out_ready = (cyc >= NR + 3);
        2:       out_ready = (cyc >= RD);
        default: out_ready = 1'b1;
      endcase
      if (poke && cyc == 3) start = 1'b1;
      #1;
      if (poke && cyc == 4) begin
        start = 1'b0;
        check("start_ignored_tpu_rst", tpu_rst, 0);
        check("start_ignored_tpu_ready", tpu_ready, 1);
      end
      if (mode == 1 && cyc == NR + 2) begin
        check("stall_overflow", overflow, 1);
        check("stall_out_valid", out_valid, 1);
        check("stall_out_data", out_data, res[0]);
        check("stall_busy", busy, 1);
      end
      if (out_valid && out_ready) begin
        if (got < expn) begin
          check("out_data", out_data, res[got]);
          check("out_last", out_last, got == NR - 1);
        end
        got++;
      end
      if (sent < NR) sent++;
      cyc++;
      step;
    end
    tpu_done  = 1'b0;
    out_ready = 1'b1;
    check("result_count", got, expn);
    check("job_end_busy", busy, 0);
    check("job_end_out_valid", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; tpu_done = 1'b0; tpu_data_out = '0;
    @(negedge clk);
    check("rst_tpu_rst", tpu_rst, 1);
    check("rst_in_ready", in_ready, 0);
    step;
    rst = 1'b0;
    step;
    check("reset_flags", {busy, out_valid, out_last, overflow, in_ready}, 5'b0);
    check("reset_out_data", out_data, 0);
    check("reset_tpu_ctl", {tpu_rst, tpu_insert_kernal, tpu_write_mode, tpu_write, tpu_ready}, 5'b0);

    // Identity kernel, matrix i, host always ready, start poked mid-COMPUTE.
    for (int k = 0; k < CD*CD; k++) kern[k] = (k == 4) ? 1 : 0;
    for (int i = 0; i < NR; i++) mat[i] = i;
    compute_golden;
    check("golden_identity", res[7], 7);
    start_job;
    load(1'b0, NW);
    check_in_compute;
    compute(0, 1'b1);
    check("identity_overflow", overflow, 0);
`ifdef CONV_SEQ_PERF_EN
    check("perf_cycles", cycles, NR);
`endif

    // Input backpressure with a dense kernel.
    for (int k = 0; k < CD*CD; k++) kern[k] = k + 1;
    for (int i = 0; i < NR; i++) mat[i] = 3*i + 1;
    compute_golden;
    start_job;
    load(1'b1, NW);
    check_in_compute;
    compute(0, 1'b0);
    check("backpressure_overflow", overflow, 0);

    // Output stall: first RD results kept, the rest dropped.
    for (int k = 0; k < CD*CD; k++) kern[k] = (k == 4) ? 1 : 0;
    for (int i = 0; i < NR; i++) mat[i] = 100 + i;
    compute_golden;
    start_job;
    load(1'b0, NW);
    compute(1, 1'b0);
    check("stall_overflow_sticky", overflow, 1);

    // Push while full with a simultaneous pop.
    for (int i = 0; i < NR; i++) mat[i] = 200 + 5*i;
    compute_golden;
    start_job;
    load(1'b0, NW);
    compute(2, 1'b0);
    check("fullpop_overflow", overflow, 0);

    // Reset during LOAD_M, then a fresh job.
    start_job;
    load(1'b0, CD*CD + 3);
    check("pre_rst_state", {tpu_write_mode, tpu_insert_kernal}, 2'b10);
    rst = 1'b1;
    #1;
    check("midrst_tpu_rst", tpu_rst, 1);
    check("midrst_in_ready", in_ready, 0);
    step;
    rst = 1'b0;
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_ctl", {in_ready, tpu_write_mode, tpu_ready, out_valid, overflow}, 5'b0);
    for (int k = 0; k < CD*CD; k++) kern[k] = (k % 2 == 0) ? 2 : 0;
    for (int i = 0; i < NR; i++) mat[i] = i ^ 5;
    compute_golden;
    step;
    start_job;
    load(1'b0, NW);
    check_in_compute;
    compute(0, 1'b0);
    check("fresh_overflow", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
